// File: rtl/rom_loader.sv
// Boot-time program-memory writer: parses a length-prefixed, checksummed byte
// stream into 16-bit words and releases the CPU from reset once it verifies.
module rom_loader #(
  parameter int ADDR_WIDTH = 16,
  parameter int MAX_WORDS  = 32768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_req,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  rom_write_enabled,
  output logic [ADDR_WIDTH-1:0] rom_address,
  output logic [15:0]           rom_write_value,
  output logic                  cpu_rst,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERROR
  } state_t;

  state_t                  state, state_nxt;
  logic [7:0]              hi_q;
  logic [7:0]              csum_q;
  logic [15:0]             len_q;
  logic [ADDR_WIDTH-1:0]   idx_q;
  logic                    accept;
  logic                    last_word;
  logic [15:0]             len_in;

  assign accept    = in_valid & in_ready;
  assign len_in    = {hi_q, in_data};
  assign last_word = (32'(idx_q) + 32'd1) == 32'(len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LEN_HI;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b1;
    done      = 1'b0;
    error     = 1'b0;
    cpu_rst   = 1'b1;
    case (state)
      LEN_HI:  if (accept) state_nxt = LEN_LO;
      LEN_LO:
        if (accept) begin
          if (32'(len_in) > 32'(MAX_WORDS)) state_nxt = ERROR;
          else if (len_in == 16'd0)         state_nxt = CHECK;
          else                              state_nxt = DATA_HI;
        end
      DATA_HI: if (accept) state_nxt = DATA_LO;
      DATA_LO: if (accept) state_nxt = last_word ? CHECK : DATA_HI;
      CHECK:   if (accept) state_nxt = (in_data == csum_q) ? DONE : ERROR;
      DONE: begin
        in_ready = 1'b0;
        done     = 1'b1;
        cpu_rst  = 1'b0;
        if (load_req) state_nxt = LEN_HI;
      end
      ERROR: begin
        in_ready = 1'b0;
        error    = 1'b1;
        if (load_req) state_nxt = LEN_HI;
      end
      default: state_nxt = LEN_HI;
    endcase
  end

  // Datapath: byte latching, running checksum and the registered ROM write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q              <= '0;
      csum_q            <= '0;
      len_q             <= '0;
      idx_q             <= '0;
      rom_write_enabled <= 1'b0;
      rom_address       <= '0;
      rom_write_value   <= '0;
    end else begin
      rom_write_enabled <= 1'b0;
      case (state)
        LEN_HI: if (accept) hi_q <= in_data;
        LEN_LO: if (accept) len_q <= len_in;
        DATA_HI:
          if (accept) begin
            hi_q   <= in_data;
            csum_q <= csum_q + in_data;
          end
        DATA_LO:
          if (accept) begin
            csum_q            <= csum_q + in_data;
            rom_write_enabled <= 1'b1;
            rom_address       <= idx_q;
            rom_write_value   <= {hi_q, in_data};
            // Hold on the final word so the index stays within MAX_WORDS-1.
            if (!last_word) idx_q <= idx_q + 1'b1;
          end
        DONE, ERROR:
          if (load_req) begin
            idx_q  <= '0;
            csum_q <= '0;
          end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_loader.sv
// Randomized self-checking bench for rom_loader against a frame-level model.
module tb_rom_loader;
  localparam int ADDR_WIDTH = 16;
  localparam int MAX_WORDS  = 32768;

  typedef logic [7:0] bq_t [$];

  logic                  clk, rst, load_req, in_valid;
  logic [7:0]            in_data;
  logic                  in_ready, rom_write_enabled, cpu_rst, done, error;
  logic [ADDR_WIDTH-1:0] rom_address;
  logic [15:0]           rom_write_value;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  rom_loader #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .load_req(load_req), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready),
    .rom_write_enabled(rom_write_enabled), .rom_address(rom_address),
    .rom_write_value(rom_write_value), .cpu_rst(cpu_rst), .done(done),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-level model: 0 = still loading, 1 = verified, 2 = rejected.
  function automatic int outcome(input bq_t f);
    int n, sum;
    n = {f[0], f[1]};
    if (n > MAX_WORDS) return 2;
    if (f.size() != 2 * n + 3) return 0;
    sum = 0;
    for (int i = 2; i < 2 + 2 * n; i++) sum += f[i];
    return ((sum % 256) == int'(f[2 + 2 * n])) ? 1 : 2;
  endfunction

  function automatic bq_t make_frame(input int n, input bit corrupt);
    bq_t f;
    int sum;
    f = {};
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    sum = 0;
    for (int i = 0; i < 2 * n; i++) begin
      f.push_back(8'($urandom_range(0, 255)));
      sum += f[f.size() - 1];
    end
    f.push_back(8'(sum + (corrupt ? 1 : 0)));
    return f;
  endfunction

  // Drives a frame byte by byte; after every edge checks the write strobe
  // against the word layout implied by the frame's length field.
  task automatic send_frame(input bq_t f, input int min_gap, input int max_gap,
                            input bit pulse_lr);
    int n, gap;
    bit exp_we;
    logic [15:0] exp_val;
    n = {f[0], f[1]};
    for (int i = 0; i < f.size(); i++) begin
      gap = $urandom_range(min_gap, max_gap);
      repeat (gap) begin
        in_valid = 1'b0;
        load_req = pulse_lr;
        @(posedge clk); #1;
        load_req = 1'b0;
        chk_cnt++;
        if (rom_write_enabled !== 1'b0)
          $display("FAIL gap_strobe byte %0d: got %b want 0", i, rom_write_enabled);
        else pass_cnt++;
      end
      in_valid = 1'b1;
      in_data  = f[i];
      @(posedge clk); #1;
      in_valid = 1'b0;
      exp_we = (n <= MAX_WORDS) && (i >= 3) && (i < 2 + 2 * n) && ((i % 2) == 1);
      chk_cnt++;
      if (rom_write_enabled !== exp_we)
        $display("FAIL strobe byte %0d: got %b want %b", i, rom_write_enabled, exp_we);
      else pass_cnt++;
      if (exp_we) begin
        exp_val = {f[i - 1], f[i]};
        chk_cnt++;
        if (rom_address !== ADDR_WIDTH'((i - 3) / 2) || rom_write_value !== exp_val)
          $display("FAIL write byte %0d: got %h@%0d want %h@%0d", i, rom_write_value,
                   rom_address, exp_val, (i - 3) / 2);
        else pass_cnt++;
      end
    end
  endtask

  task automatic check_end(input string name, input int exp);
    logic exp_done, exp_err;
    exp_done = (exp == 1);
    exp_err  = (exp == 2);
    chk_cnt++;
    if (done !== exp_done || error !== exp_err || cpu_rst !== !exp_done ||
        in_ready !== (exp == 0))
      $display("FAIL %s: got done=%b error=%b cpu_rst=%b in_ready=%b want %b %b %b %b",
               name, done, error, cpu_rst, in_ready, exp_done, exp_err, !exp_done, exp == 0);
    else pass_cnt++;
    @(posedge clk); #1;
    chk_cnt++;
    if (rom_write_enabled !== 1'b0 || done !== exp_done || error !== exp_err)
      $display("FAIL %s_hold: got we=%b done=%b error=%b want 0 %b %b",
               name, rom_write_enabled, done, error, exp_done, exp_err);
    else pass_cnt++;
  endtask

  task automatic restart();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
    chk_cnt++;
    if (in_ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || cpu_rst !== 1'b1)
      $display("FAIL restart: got ready=%b done=%b error=%b cpu_rst=%b want 1 0 0 1",
               in_ready, done, error, cpu_rst);
    else pass_cnt++;
  endtask

  task automatic check_reset_values(input string name);
    chk_cnt++;
    if (in_ready !== 1'b1 || rom_write_enabled !== 1'b0 || rom_address !== '0 ||
        rom_write_value !== 16'h0 || cpu_rst !== 1'b1 || done !== 1'b0 || error !== 1'b0)
      $display("FAIL %s: got ready=%b we=%b addr=%h val=%h cpu_rst=%b done=%b error=%b want 1 0 0 0 1 0 0",
               name, in_ready, rom_write_enabled, rom_address, rom_write_value,
               cpu_rst, done, error);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b1; load_req = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    #1;
    check_reset_values("reset_state");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_values("after_reset");
  endtask

  task automatic test_basic();
    bq_t f = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    send_frame(f, 0, 0, 1'b0);
    check_end("basic", outcome(f));
    restart();
  endtask

  task automatic test_bad_check();
    bq_t bad  = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBF};
    bq_t good = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    send_frame(bad, 0, 0, 1'b0);
    check_end("bad_check", outcome(bad));
    restart();
    send_frame(good, 0, 0, 1'b0);
    check_end("reload", outcome(good));
    restart();
  endtask

  task automatic test_length();
    bq_t over = {8'h80, 8'h01};
    bq_t z_ok = {8'h00, 8'h00, 8'h00};
    bq_t z_bad = {8'h00, 8'h00, 8'h01};
    bq_t maxl = {8'h80, 8'h00};
    send_frame(over, 0, 0, 1'b0);
    check_end("too_long", outcome(over));
    restart();
    send_frame(z_ok, 0, 0, 1'b0);
    check_end("empty_ok", outcome(z_ok));
    restart();
    send_frame(z_bad, 0, 0, 1'b0);
    check_end("empty_bad", outcome(z_bad));
    restart();
    // Exactly MAX_WORDS is legal: the loader must move on to the payload.
    send_frame(maxl, 0, 0, 1'b0);
    check_end("max_len", outcome(maxl));
    rst = 1'b1; #1 rst = 1'b0;
  endtask

  task automatic test_gaps();
    bq_t f;
    for (int k = 0; k < 8; k++) begin
      f = make_frame($urandom_range(1, 6), ($urandom_range(0, 2) == 0));
      send_frame(f, 0, 5, 1'b0);
      check_end("gaps", outcome(f));
      restart();
    end
  endtask

  task automatic test_back_to_back();
    bq_t f;
    for (int k = 0; k < 4; k++) begin
      f = make_frame($urandom_range(1, 8), 1'b0);
      send_frame(f, 0, 0, 1'b0);
      check_end("back_to_back", outcome(f));
      restart();
    end
  endtask

  task automatic test_load_req_ignored();
    bq_t f = {8'h00, 8'h01, 8'hAA, 8'hBB, 8'h65};
    send_frame(f, 1, 1, 1'b1);
    check_end("load_req_ignored", outcome(f));
    restart();
  endtask

  task automatic test_mid_reset();
    bq_t full = {8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE};
    bq_t part;
    // Cut after byte 12, then after 34 where a write strobe is in flight.
    for (int cut = 3; cut <= 4; cut++) begin
      part = full[0:cut-1];
      send_frame(part, 0, 0, 1'b0);
      rst = 1'b1;
      #1;
      check_reset_values("async_reset");
      @(posedge clk); #1;
      check_reset_values("held_reset");
      rst = 1'b0;
      send_frame(full, 0, 0, 1'b0);
      check_end("after_mid_reset", outcome(full));
      restart();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_check();
    test_length();
    test_back_to_back();
    test_gaps();
    test_load_req_ignored();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
